tape_unit: RTL and testbench
============================

TAPE_UNIT -- requirements
Module: tape_unit

Interface
REQ-001 SHALL have parameter SYM_W, default 3, tape symbol width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, number of tape cells; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter HEAD_INIT, default 256, head address after reset.
REQ-004 SHALL have parameter WRAP, default 0, edge mode: 0 halts at a tape edge, 1 wraps.
REQ-005 SHALL have parameter CNT_W, default 32, step counter width.
REQ-006 SHALL have parameter MAX_STEPS, default 250000, step limit; 0 means no limit.
REQ-007 SHALL have parameter BLANK, default 0, symbol written by clear.
REQ-008 SHALL have ports, one per line (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  leave LOAD and begin stepping.
- clear  in  1  in LOAD, sweep the whole tape to BLANK.
- load_en, load_addr, load_sym  in  1/ADDR_W/SYM_W  tape preload write.
- resp_valid  in  1  core response valid.
- new_sym  in  SYM_W  symbol to write at head.
- direction  in  1  1 = head +1, 0 = head -1.
- halt_req  in  1  core requests halt.
- sym  out  SYM_W  symbol under head.
- sym_valid  out  1  one-cycle strobe qualifying sym.
- head  out  ADDR_W  current head address.
- step_count  out  CNT_W  completed steps.
- seq  out  3  state: 0 LOAD, 1 CLEAR, 2 READ, 3 WAIT, 4 WRITE, 7 HALT.
- halted  out  1  seq == HALT.
- halt_cause  out  2  0 none, 1 core, 2 edge, 3 limit.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_sym  out  SYM_W  tape[dbg_addr], registered.

Function
REQ-009 SHALL implement the tape as DEPTH x SYM_W storage with one write per cycle.
REQ-010 LOAD: load_en writes tape[load_addr]=load_sym; load_en is ignored in every other state.
REQ-011 LOAD: clear -> CLEAR; clear has priority over start when both are asserted; a load_en write in the same cycle is still performed.
REQ-012 CLEAR: write BLANK to addresses 0..DEPTH-1, one per cycle in ascending order, DEPTH cycles, then -> LOAD; start is ignored during CLEAR.
REQ-013 LOAD: start -> READ; a load_en write in the same cycle is performed before the first READ.
REQ-014 READ: register sym=tape[head] and assert sym_valid for exactly the first cycle of WAIT; -> WAIT.
REQ-015 WAIT: hold until resp_valid=1, sampling new_sym, direction and halt_req in that cycle; resp_valid is honoured even in the sym_valid cycle.
REQ-016 WAIT with resp_valid and halt_req: -> HALT, cause 1; no tape write, head unchanged, no count increment.
REQ-017 WAIT with resp_valid and !halt_req: -> WRITE.
REQ-018 WRITE: write tape[head]=sampled new_sym, move head one cell, increment step_count (saturate at all-ones); -> READ unless a halt condition applies.
REQ-019 Edge condition: left move at head 0, or right move at head DEPTH-1.
REQ-020 Edge with WRAP=0: perform the write, leave head unchanged, -> HALT, cause 2.
REQ-021 Edge with WRAP=1: head moves to DEPTH-1 or 0 respectively, then normal flow.
REQ-022 If MAX_STEPS!=0 and the incremented step_count equals MAX_STEPS: -> HALT, cause 3; edge (cause 2) takes priority when both occur in the same WRITE.
REQ-023 HALT is absorbing: only reset exits it; dbg port stays live in HALT.
REQ-024 One step is a minimum of 3 cycles (READ, WAIT, WRITE).
REQ-025 dbg_sym SHALL equal tape[dbg_addr] one cycle after dbg_addr is presented, in any state; a write to the same cell in that cycle returns the old value.

Reset
REQ-026 Reset SHALL give: seq=LOAD, head=HEAD_INIT, step_count=0, sym=0, sym_valid=0, halt_cause=0, halted=0.
REQ-027 Reset SHALL NOT alter tape contents.
REQ-028 Reset SHALL abort any state, including CLEAR mid-sweep, on the next clock edge.

Verification
REQ-029 Preload tape[256]=5, start; core answers new_sym=2, direction=1 -> sym=5 with sym_valid for 1 cycle, then tape[256]=2, head=257, step_count=1.
REQ-030 WRAP=0, HEAD_INIT=0, left move -> tape[0] written, head=0, halted=1, halt_cause=2.
REQ-031 WRAP=1, HEAD_INIT=DEPTH-1, right move -> head=0, seq returns to READ.
REQ-032 MAX_STEPS=3, core always moves right with no halt -> halt_cause=3 with step_count=3; halt_req on the 2nd response -> halt_cause=1, step_count=1.
REQ-033 clear with start asserted in the same cycle -> CLEAR for 512 cycles, dbg_sym=BLANK at addresses 0 and 511, then LOAD.
REQ-034 Reset asserted while in WAIT after 10 steps -> LOAD, head=256, step_count=0, and written cells keep their values.

Source files
------------

// File: rtl/tape_unit.sv
// tape_unit: single-head symbol tape with preload/clear, core handshake and debug read port.
module tape_unit #(
  parameter int SYM_W     = 3,
  parameter int DEPTH     = 512,
  parameter int HEAD_INIT = 256,
  parameter int WRAP      = 0,
  parameter int CNT_W     = 32,
  parameter int MAX_STEPS = 250000,
  parameter int BLANK     = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [SYM_W-1:0]  load_sym,
  input  logic              resp_valid,
  input  logic [SYM_W-1:0]  new_sym,
  input  logic              direction,
  input  logic              halt_req,
  output logic [SYM_W-1:0]  sym,
  output logic              sym_valid,
  output logic [ADDR_W-1:0] head,
  output logic [CNT_W-1:0]  step_count,
  output logic [2:0]        seq,
  output logic              halted,
  output logic [1:0]        halt_cause,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [SYM_W-1:0]  dbg_sym
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLEAR = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  STEP_LIMIT = CNT_W'(MAX_STEPS);

  logic [SYM_W-1:0]  tape_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]  step_q, step_d, step_inc;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic              sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]  nsym_q, nsym_d;
  logic              dir_q, dir_d;
  logic [1:0]        cause_q, cause_d;
  logic [SYM_W-1:0]  dbg_sym_q, dbg_sym_d;

  logic              tape_we;
  logic [ADDR_W-1:0] tape_waddr;
  logic [SYM_W-1:0]  tape_wdata;
  logic              at_edge;

  // Next-state, next-output and tape write-port selection
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    clr_addr_d  = clr_addr_q;
    step_d      = step_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    nsym_d      = nsym_q;
    dir_d       = dir_q;
    cause_d     = cause_q;
    tape_we     = 1'b0;
    tape_waddr  = head_q;
    tape_wdata  = nsym_q;
    dbg_sym_d   = tape_q[dbg_addr];
    step_inc    = (&step_q) ? step_q : step_q + 1'b1;
    at_edge     = dir_q ? (head_q == ADDR_LAST) : (head_q == '0);

    unique case (state_q)
      S_LOAD: begin
        if (load_en) begin
          tape_we    = 1'b1;
          tape_waddr = load_addr;
          tape_wdata = load_sym;
        end
        if (clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (start) begin
          state_d = S_READ;
        end
      end
      S_CLEAR: begin
        tape_we    = 1'b1;
        tape_waddr = clr_addr_q;
        tape_wdata = SYM_W'(BLANK);
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_LAST) state_d = S_LOAD;
      end
      S_READ: begin
        sym_d       = tape_q[head_q];
        sym_valid_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (resp_valid) begin
          nsym_d = new_sym;
          dir_d  = direction;
          if (halt_req) begin
            state_d = S_HALT;
            cause_d = 2'd1;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        tape_we = 1'b1;
        step_d  = step_inc;
        state_d = S_READ;
        if (at_edge && WRAP == 0) begin
          state_d = S_HALT;
          cause_d = 2'd2;
        end else begin
          if (at_edge) head_d = dir_q ? '0 : ADDR_LAST;
          else         head_d = dir_q ? head_q + 1'b1 : head_q - 1'b1;
          if (MAX_STEPS != 0 && step_inc == STEP_LIMIT) begin
            state_d = S_HALT;
            cause_d = 2'd3;
          end
        end
      end
      S_HALT: begin
      end
      default: state_d = S_HALT;
    endcase
  end

  // Control and output registers; debug read register runs in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_LOAD;
      head_q      <= ADDR_W'(HEAD_INIT);
      clr_addr_q  <= '0;
      step_q      <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      nsym_q      <= '0;
      dir_q       <= 1'b0;
      cause_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      clr_addr_q  <= clr_addr_d;
      step_q      <= step_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      nsym_q      <= nsym_d;
      dir_q       <= dir_d;
      cause_q     <= cause_d;
    end
    dbg_sym_q <= dbg_sym_d;
  end

  // Tape storage: one write per cycle, suppressed while reset aborts the current state
  always_ff @(posedge clock) begin
    if (tape_we && !reset) tape_q[tape_waddr] <= tape_wdata;
  end

  assign sym        = sym_q;
  assign sym_valid  = sym_valid_q;
  assign head       = head_q;
  assign step_count = step_q;
  assign seq        = state_q;
  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign dbg_sym    = dbg_sym_q;

endmodule

// File: tb/tb_tape_unit.sv
// tb_tape_unit: three tape_unit configurations driven by randomized core responses
// and compared against a transaction-level tape model.
module tb_tape_unit;

  localparam int N     = 3;
  localparam int DEPTH = 512;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0] reset_v, start_v, clear_v, load_en_v, resp_valid_v, dir_v, halt_req_v;
  logic [8:0]   load_addr_v [N];
  logic [2:0]   load_sym_v  [N];
  logic [2:0]   new_sym_v   [N];
  logic [8:0]   dbg_addr_v  [N];

  logic [2:0]  a_sym, b_sym, c_sym, a_seq, b_seq, c_seq, a_dbg, b_dbg, c_dbg;
  logic        a_sv, b_sv, c_sv, a_hlt, b_hlt, c_hlt;
  logic [8:0]  a_head, b_head, c_head;
  logic [1:0]  a_cause, b_cause, c_cause;
  logic [31:0] a_step, c_step;
  logic [1:0]  b_step;

  // u0: defaults; u1: left edge start, halting edges, 2-bit counter, no limit, BLANK=6;
  // u1 and u2 differ from defaults only through named overrides
  tape_unit u_a (
    .clock(clock), .reset(reset_v[0]), .start(start_v[0]), .clear(clear_v[0]),
    .load_en(load_en_v[0]), .load_addr(load_addr_v[0]), .load_sym(load_sym_v[0]),
    .resp_valid(resp_valid_v[0]), .new_sym(new_sym_v[0]), .direction(dir_v[0]),
    .halt_req(halt_req_v[0]), .sym(a_sym), .sym_valid(a_sv), .head(a_head),
    .step_count(a_step), .seq(a_seq), .halted(a_hlt), .halt_cause(a_cause),
    .dbg_addr(dbg_addr_v[0]), .dbg_sym(a_dbg)
  );

  tape_unit #(.HEAD_INIT(0), .WRAP(0), .CNT_W(2), .MAX_STEPS(0), .BLANK(6)) u_b (
    .clock(clock), .reset(reset_v[1]), .start(start_v[1]), .clear(clear_v[1]),
    .load_en(load_en_v[1]), .load_addr(load_addr_v[1]), .load_sym(load_sym_v[1]),
    .resp_valid(resp_valid_v[1]), .new_sym(new_sym_v[1]), .direction(dir_v[1]),
    .halt_req(halt_req_v[1]), .sym(b_sym), .sym_valid(b_sv), .head(b_head),
    .step_count(b_step), .seq(b_seq), .halted(b_hlt), .halt_cause(b_cause),
    .dbg_addr(dbg_addr_v[1]), .dbg_sym(b_dbg)
  );

  tape_unit #(.HEAD_INIT(511), .WRAP(1), .MAX_STEPS(3)) u_c (
    .clock(clock), .reset(reset_v[2]), .start(start_v[2]), .clear(clear_v[2]),
    .load_en(load_en_v[2]), .load_addr(load_addr_v[2]), .load_sym(load_sym_v[2]),
    .resp_valid(resp_valid_v[2]), .new_sym(new_sym_v[2]), .direction(dir_v[2]),
    .halt_req(halt_req_v[2]), .sym(c_sym), .sym_valid(c_sv), .head(c_head),
    .step_count(c_step), .seq(c_seq), .halted(c_hlt), .halt_cause(c_cause),
    .dbg_addr(dbg_addr_v[2]), .dbg_sym(c_dbg)
  );

  // Per-configuration parameters as seen by the model
  function automatic int p_head0(input int k);
    case (k) 0: return 256; 1: return 0; default: return 511; endcase
  endfunction
  function automatic bit p_wrap(input int k);
    return (k == 2);
  endfunction
  function automatic longint p_max(input int k);
    case (k) 0: return 250000; 1: return 0; default: return 3; endcase
  endfunction
  function automatic longint p_cmax(input int k);
    return (k == 1) ? 64'd3 : 64'hFFFF_FFFF;
  endfunction
  function automatic int p_blank(input int k);
    return (k == 1) ? 6 : 0;
  endfunction

  // Model: tape cells (-1 = unknown), head, steps, halt status
  int     m_tape  [N][DEPTH];
  int     m_head  [N];
  longint m_steps [N];
  int     m_cause [N];
  bit     m_halted[N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic string tag(input int k, input string s);
    return $sformatf("u%0d.%s", k, s);
  endfunction

  logic [2:0] o_sym, o_seq, o_dbg;
  logic       o_sv, o_halted;
  logic [8:0] o_head;
  logic [1:0] o_cause;
  longint     o_step;

  task automatic sample(input int k);
    case (k)
      0: begin o_sym = a_sym; o_seq = a_seq; o_dbg = a_dbg; o_sv = a_sv; o_halted = a_hlt;
               o_head = a_head; o_cause = a_cause; o_step = a_step; end
      1: begin o_sym = b_sym; o_seq = b_seq; o_dbg = b_dbg; o_sv = b_sv; o_halted = b_hlt;
               o_head = b_head; o_cause = b_cause; o_step = b_step; end
      default: begin o_sym = c_sym; o_seq = c_seq; o_dbg = c_dbg; o_sv = c_sv; o_halted = c_hlt;
               o_head = c_head; o_cause = c_cause; o_step = c_step; end
    endcase
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic quiet(input int k);
    load_en_v[k] = 1'b0; start_v[k] = 1'b0; clear_v[k] = 1'b0;
    halt_req_v[k] = 1'b0; resp_valid_v[k] = 1'b0;
  endtask

  // Inputs that must have no effect outside their owning state
  task automatic noise(input int k);
    load_en_v[k]   = 1'($urandom_range(1));
    load_addr_v[k] = 9'($urandom_range(DEPTH - 1));
    load_sym_v[k]  = 3'($urandom_range(7));
    start_v[k]     = 1'($urandom_range(1));
    clear_v[k]     = 1'($urandom_range(1));
    new_sym_v[k]   = 3'($urandom_range(7));
    dir_v[k]       = 1'($urandom_range(1));
    halt_req_v[k]  = 1'($urandom_range(1));
  endtask

  task automatic check_regs(input int k, input int exp_seq);
    sample(k);
    check(tag(k, "seq"),    o_seq,    exp_seq);
    check(tag(k, "head"),   o_head,   m_head[k]);
    check(tag(k, "steps"),  o_step,   m_steps[k]);
    check(tag(k, "cause"),  o_cause,  m_cause[k]);
    check(tag(k, "halted"), o_halted, m_halted[k]);
  endtask

  // One core response applied to the model, straight from the behavioural rules
  task automatic model_step(input int k, input int ns, input bit dir, input bit hreq);
    int tgt;
    if (hreq) begin
      m_halted[k] = 1'b1;
      m_cause[k]  = 1;
      return;
    end
    m_tape[k][m_head[k]] = ns;
    if (m_steps[k] < p_cmax(k)) m_steps[k] = m_steps[k] + 1;
    tgt = m_head[k] + (dir ? 1 : -1);
    if (tgt < 0 || tgt >= DEPTH) begin
      if (p_wrap(k)) begin
        tgt = (tgt + DEPTH) % DEPTH;
      end else begin
        tgt = m_head[k];
        m_halted[k] = 1'b1;
        m_cause[k]  = 2;
      end
    end
    m_head[k] = tgt;
    if (!m_halted[k] && p_max(k) != 0 && m_steps[k] == p_max(k)) begin
      m_halted[k] = 1'b1;
      m_cause[k]  = 3;
    end
  endtask

  task automatic do_reset(input int k);
    quiet(k);
    reset_v[k] = 1'b1;
    tick();
    reset_v[k] = 1'b0;
    m_head[k] = p_head0(k); m_steps[k] = 0; m_cause[k] = 0; m_halted[k] = 1'b0;
    check_regs(k, 0);
    check(tag(k, "rst_sym"), o_sym, 0);
    check(tag(k, "rst_sv"),  o_sv,  0);
  endtask

  task automatic do_load(input int k, input int a, input int s);
    load_en_v[k] = 1'b1; load_addr_v[k] = 9'(a); load_sym_v[k] = 3'(s);
    tick();
    load_en_v[k] = 1'b0;
    m_tape[k][a] = s;
  endtask

  task automatic do_start(input int k, input bit with_load);
    int a, s;
    start_v[k] = 1'b1;
    if (with_load) begin
      a = $urandom_range(1) ? m_head[k] : int'($urandom_range(DEPTH - 1));
      s = $urandom_range(7);
      load_en_v[k] = 1'b1; load_addr_v[k] = 9'(a); load_sym_v[k] = 3'(s);
      m_tape[k][a] = s;
    end
    tick();
    start_v[k] = 1'b0; load_en_v[k] = 1'b0;
    sample(k);
    check(tag(k, "start_seq"), o_seq, 2);
  endtask

  task automatic wait_valid(input int k, output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample(k);
      if (o_sv) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(tag(k, "sym_valid_timeout"), 0, 1);
  endtask

  task automatic do_step(input int k, input int ns, input bit dir, input bit hreq);
    bit got;
    int delay, old;
    wait_valid(k, got);
    if (!got) return;
    check(tag(k, "seq_wait"), o_seq, 3);
    if (m_tape[k][m_head[k]] >= 0) check(tag(k, "sym"), o_sym, m_tape[k][m_head[k]]);
    delay = $urandom_range(2);
    for (int d = 0; d < delay; d++) begin
      noise(k);
      tick();
      sample(k);
      check(tag(k, "sv_one_cycle"), o_sv,  0);
      check(tag(k, "seq_hold"),     o_seq, 3);
    end
    quiet(k);
    resp_valid_v[k] = 1'b1; new_sym_v[k] = 3'(ns); dir_v[k] = dir; halt_req_v[k] = hreq;
    tick();
    noise(k);
    resp_valid_v[k] = 1'b0;
    sample(k);
    check(tag(k, "sv_after_resp"), o_sv, 0);
    if (hreq) begin
      model_step(k, ns, dir, 1'b1);
      check_regs(k, 7);
    end else begin
      check(tag(k, "seq_write"), o_seq, 4);
      old = m_tape[k][m_head[k]];
      dbg_addr_v[k] = 9'(m_head[k]);
      tick();
      sample(k);
      if (old >= 0) check(tag(k, "dbg_old"), o_dbg, old);
      model_step(k, ns, dir, 1'b0);
      check_regs(k, m_halted[k] ? 7 : 2);
    end
    quiet(k);
  endtask

  task automatic do_clear(input int k);
    int n;
    clear_v[k] = 1'b1; start_v[k] = 1'b1;
    tick();
    clear_v[k] = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      sample(k);
      if (o_seq != 3'd1) break;
      n++;
      if (n == 10) start_v[k] = 1'b0;
      tick();
    end
    start_v[k] = 1'b0;
    check(tag(k, "clear_len"),  n,     DEPTH);
    check(tag(k, "clear_exit"), o_seq, 0);
    for (int a = 0; a < DEPTH; a++) m_tape[k][a] = p_blank(k);
    dbg_addr_v[k] = 9'd0;
    tick(); sample(k);
    check(tag(k, "clear_dbg0"), o_dbg, p_blank(k));
    dbg_addr_v[k] = 9'(DEPTH - 1);
    tick(); sample(k);
    check(tag(k, "clear_dbg_last"), o_dbg, p_blank(k));
  endtask

  task automatic scan(input int k, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      dbg_addr_v[k] = 9'(a);
      tick();
      sample(k);
      if (m_tape[k][a] >= 0) check(tag(k, $sformatf("tape%0d", a)), o_dbg, m_tape[k][a]);
    end
  endtask

  task automatic poke_halt(input int k);
    for (int i = 0; i < 4; i++) begin
      noise(k);
      resp_valid_v[k] = 1'b1;
      tick();
      sample(k);
      check(tag(k, "halt_hold"), o_seq, 7);
    end
    quiet(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int np;
    reset_v = '1; start_v = '0; clear_v = '0; load_en_v = '0;
    resp_valid_v = '0; dir_v = '0; halt_req_v = '0;
    for (int k = 0; k < N; k++) begin
      load_addr_v[k] = '0; load_sym_v[k] = '0; new_sym_v[k] = '0; dbg_addr_v[k] = '0;
      for (int a = 0; a < DEPTH; a++) m_tape[k][a] = -1;
    end
    tick(); tick();
    for (int k = 0; k < N; k++) do_reset(k);

    // Clear sweeps (start held alongside clear must be ignored)
    do_clear(0);
    for (int a = 0; a < 16; a++) do_load(1, a, $urandom_range(5));
    clear_v[1] = 1'b1;
    tick();
    clear_v[1] = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    sample(1);
    check(tag(1, "clr_mid"), o_seq, 1);
    for (int a = 0; a < 7; a++) m_tape[1][a] = 6;
    m_tape[1][7] = -1;
    do_reset(1);
    scan(1, 0, 15);
    do_clear(1);
    do_clear(2);

    // Basic step, then reset from WAIT after ten steps
    do_load(0, 256, 5);
    do_start(0, 1'b0);
    do_step(0, 2, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) do_step(0, $urandom_range(7), 1'($urandom_range(1)), 1'b0);
    wait_valid(0, got);
    do_reset(0);
    scan(0, 246, 266);

    // Randomized sessions on the default configuration
    for (int s = 0; s < 5; s++) begin
      np = $urandom_range(3);
      for (int p = 0; p < np; p++) do_load(0, 246 + $urandom_range(20), $urandom_range(7));
      do_start(0, 1'($urandom_range(1)));
      for (int i = 0; i < 30 && !m_halted[0]; i++)
        do_step(0, $urandom_range(7), 1'($urandom_range(1)), $urandom_range(19) == 0);
      if (m_halted[0]) poke_halt(0);
      else wait_valid(0, got);
      do_reset(0);
    end
    scan(0, 220, 292);

    // Halting edge at address 0, counter saturation, biased random walk
    do_start(1, 1'b0);
    do_step(1, 3, 1'b0, 1'b0);
    poke_halt(1);
    scan(1, 0, 0);
    do_reset(1);
    do_start(1, 1'b0);
    for (int i = 0; i < 5; i++) do_step(1, $urandom_range(7), 1'b1, 1'b0);
    for (int i = 0; i < 30 && !m_halted[1]; i++)
      do_step(1, $urandom_range(7), $urandom_range(3) == 0, $urandom_range(24) == 0);
    if (!m_halted[1]) wait_valid(1, got);
    do_reset(1);
    scan(1, 0, 40);

    // Wrapping edges and step limit
    do_start(2, 1'b0);
    do_step(2, 1, 1'b1, 1'b0);
    do_step(2, 2, 1'b1, 1'b0);
    do_step(2, 3, 1'b1, 1'b0);
    poke_halt(2);
    do_reset(2);
    do_start(2, 1'b0);
    do_step(2, 4, 1'b1, 1'b0);
    do_step(2, 5, 1'b0, 1'b1);
    do_reset(2);
    do_start(2, 1'b0);
    do_step(2, 6, 1'b1, 1'b0);
    do_step(2, 7, 1'b0, 1'b0);
    do_step(2, 1, 1'b0, 1'b0);
    do_reset(2);
    do_start(2, 1'($urandom_range(1)));
    for (int i = 0; i < 5 && !m_halted[2]; i++)
      do_step(2, $urandom_range(7), 1'($urandom_range(1)), $urandom_range(9) == 0);
    scan(2, 0, 3);
    scan(2, 505, 511);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
